alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 23 ++
 rtl/alu_mc_mul.sv | 50 +++++
 rtl/alu_mc.sv | 139 +++++++++++++
 tb/tb_alu_mc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared op-codes, FSM state encoding and op decode helper for alu_mc.
// MUL support is compiled in only when ALU_MC_MUL_EN is defined.
package alu_mc_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

    // SUB and SLT both run the adder as A + ~B + 1
    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// WIDTH iterations after start; done flags the final iteration cycle.
module alu_mc_mul #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    // acc holds the full low-WIDTH product on the cycle after done
    assign done    = busy && (cnt == CNT_W'(WIDTH - 1));
    assign product = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            a_sh <= a;
            b_sh <= b;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (b_sh[0])
                acc <= acc + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle logic/arith ops
// and, when ALU_MC_MUL_EN is defined, an iterative MUL (IDLE->MUL->HOLD).
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int MUL_CYCLES_LOG2 = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero,
    output logic             overflow,
    output logic             cout,
    output logic             bad_op
);

    if (WIDTH < 4 || (2 ** MUL_CYCLES_LOG2) < WIDTH) begin : g_cfg_chk
        $error("alu_mc: WIDTH must be >= 4 and 2**MUL_CYCLES_LOG2 >= WIDTH");
    end

    state_t state, state_nxt;
    logic   accept, take, mul_op;

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;

    logic             sub_mode, carry, ovf;
    logic [WIDTH-1:0] b_eff, sum;

    assign sub_mode     = op_is_sub(op);
    assign b_eff        = sub_mode ? ~dataB : dataB;
    assign {carry, sum} = {1'b0, dataA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    assign ovf          = (dataA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != dataA[WIDTH-1]);

    logic [WIDTH-1:0] res_d;
    logic             res_ovf, res_co, res_bad;

    always_comb begin
        res_d   = '0;
        res_ovf = 1'b0;
        res_co  = 1'b0;
        res_bad = 1'b0;
        case (op)
            OP_AND: res_d = dataA & dataB;
            OP_OR:  res_d = dataA | dataB;
            OP_NOR: res_d = ~(dataA | dataB);
            OP_ADD, OP_SUB: begin
                res_d   = sum;
                res_ovf = ovf;
                res_co  = carry;
            end
            OP_SLT: res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
`ifdef ALU_MC_MUL_EN
            OP_MUL: res_d = '0;
`endif
            default: res_bad = 1'b1;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign mul_op = (op == OP_MUL);

    alu_mc_mul #(
        .WIDTH (WIDTH),
        .CNT_W (MUL_CYCLES_LOG2)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && mul_op),
        .a       (dataA),
        .b       (dataB),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && mul_op) state_nxt = ST_MUL;
            ST_MUL:  if (mul_done) state_nxt = ST_HOLD;
            ST_HOLD: if (!out_valid || out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end
`else
    assign mul_op = 1'b0;

    always_comb begin
        state_nxt = ST_IDLE;
    end
`endif

    assign zero = (dataOut == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            dataOut   <= '0;
            overflow  <= 1'b0;
            cout      <= 1'b0;
            bad_op    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && !mul_op) begin
                out_valid <= 1'b1;
                dataOut   <= res_d;
                overflow  <= res_ovf;
                cout      <= res_co;
                bad_op    <= res_bad;
            end
`ifdef ALU_MC_MUL_EN
            else if (state == ST_HOLD && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                dataOut   <= mul_product;
                overflow  <= 1'b0;
                cout      <= 1'b0;
                bad_op    <= 1'b0;
            end
`endif
            else if (take) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed + scoreboard bench for alu_mc (WIDTH=32); MUL checks follow ALU_MC_MUL_EN.
`timescale 1ns/1ps
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] dataA, dataB, dataOut;
    logic [2:0]   op;
    logic         zero, overflow, cout, bad_op;

    always #5 clk = ~clk;

    alu_mc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dataA(dataA), .dataB(dataB), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .dataOut(dataOut), .zero(zero),
        .overflow(overflow), .cout(cout), .bad_op(bad_op)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         ovf;
        logic         co;
        logic         bad;
    } exp_t;

    exp_t sb[$];
    int   errs = 0;
    int   checks = 0;
    int   last_wait = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sr;
        logic [63:0] ur;
        e.d = '0; e.ovf = 1'b0; e.co = 1'b0; e.bad = 1'b0;
        case (o)
            3'b000: e.d = a & b;
            3'b001: e.d = a | b;
            3'b100: e.d = ~(a | b);
            3'b010: begin
                sr    = longint'($signed(a)) + longint'($signed(b));
                ur    = 64'(a) + 64'(b);
                e.d   = a + b;
                e.co  = (ur > 64'h0000_0000_FFFF_FFFF);
                e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'b110: begin
                sr    = longint'($signed(a)) - longint'($signed(b));
                e.d   = a - b;
                e.co  = (a >= b);
                e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'b111: e.d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_MC_MUL_EN
            3'b011: begin
                ur  = 64'(a) * 64'(b);
                e.d = ur[W-1:0];
            end
`endif
            default: e.bad = 1'b1;
        endcase
        return e;
    endfunction

    // Output-side scoreboard: compare on every transfer out
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("data", dataOut, e.d);
                chk("zero", 32'(zero), 32'(e.d == '0));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("cout", 32'(cout), 32'(e.co));
                chk("bad_op", 32'(bad_op), 32'(e.bad));
            end
        end
    end

    // Called just after a negedge with the operation already driven
    task automatic wait_accept(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            n++;
        end
        last_wait = n;
        chk("accept_timeout", 32'(in_ready), 32'd1);
        if (in_ready === 1'b1) begin
            sb.push_back(model(o, a, b));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        op       = o;
        dataA    = a;
        dataB    = b;
    endtask

    task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        drive(o, a, b);
        #1;
        wait_accept(o, a, b);
    endtask

    logic [2:0] ops[7] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101};

    initial begin
        int   k;
        exp_t dummy;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'b000; dataA = '0; dataB = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dataOut", dataOut, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_flags", {29'd0, overflow, cout, bad_op}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        send(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_next_cycle_valid", 32'(out_valid), 32'd1);
        send(3'b110, 32'd5, 32'd5);
        send(3'b111, 32'h8000_0000, 32'd1);
        send(3'b111, 32'd1, 32'h8000_0000);
        send(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
        send(3'b001, 32'hF000_0000, 32'h0000_000F);
        send(3'b100, 32'hFFFF_0000, 32'h0000_FFFF);
        send(3'b101, 32'h1234_5678, 32'h1);
        send(3'b110, 32'h8000_0000, 32'd1);

        for (int i = 0; i < 24; i++) begin
            send(ops[$urandom_range(0, 6)], $urandom, $urandom);
            chk("b2b_wait", last_wait, 32'd0);
        end

        // Back-pressure: result must hold still while out_ready is low
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        send(3'b010, 32'h1234_5678, 32'h1111_1111);
        repeat (4) begin
            @(negedge clk);
            #3;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", dataOut, 32'h2345_6789);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        drive(3'b001, 32'h0000_00A0, 32'h0000_000B);
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        wait_accept(3'b001, 32'h0000_00A0, 32'h0000_000B);
        chk("release_same_cycle", last_wait, 32'd0);

`ifdef ALU_MC_MUL_EN
        send(3'b011, 32'h0000_FFFF, 32'h0001_0001);
        k = 0;
        while (out_valid !== 1'b1 && k < 100) begin
            chk("mul_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            k++;
        end
        chk("mul_latency", k, 32'd33);
        send(3'b011, 32'h1234_5678, 32'h9ABC_DEF1);
        send(3'b010, 32'd3, 32'd4);

        // Abort a multiply with a reset pulse at its 10th cycle
        send(3'b011, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        dummy = sb.pop_back();
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_zero", 32'(zero), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_result", 32'(out_valid), 32'd0);
        send(3'b010, 32'd10, 32'd20);
`else
        send(3'b011, 32'd7, 32'd9);
        send(3'b011, 32'hFFFF_FFFF, 32'h2);
        send(3'b010, 32'd10, 32'd20);
`endif

        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #3;
        chk("drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
